// File: rtl/mymem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mymem_ctrl
// Description : Command front-end for the 1024x64 RoCC scratchpad. Sequences
//               write/swap, read and atomic-add commands onto a single-port
//               memory with one request in flight, and returns results.
// Revision    : 1.0 - initial release
// ============================================================================
module mymem_ctrl #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 64,
  parameter int TAG_W  = 5
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [6:0]        cmd_funct,
  input  logic [DATA_W-1:0] cmd_rs1,
  input  logic [DATA_W-1:0] cmd_rs2,
  input  logic [TAG_W-1:0]  cmd_rd,
  input  logic              cmd_xd,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [TAG_W-1:0]  resp_rd,
  output logic [DATA_W-1:0] resp_data,
  output logic              mem_rqvalid,
  output logic [TAG_W-1:0]  mem_rqaddr,
  output logic              mem_wren,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wrdata,
  input  logic              mem_rdvalid,
  input  logic [TAG_W-1:0]  mem_rdaddr,
  input  logic [DATA_W-1:0] mem_rddata,
  output logic              busy
);

  localparam logic [6:0] c_FUNCT_WRITE = 7'd0;
  localparam logic [6:0] c_FUNCT_READ  = 7'd1;
  localparam logic [6:0] c_FUNCT_ADD   = 7'd2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_WB    = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [6:0]        r_funct;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_rs2;
  logic [TAG_W-1:0]  r_rd;
  logic              r_xd;
  logic              r_resp_valid;
  logic [TAG_W-1:0]  r_resp_rd;
  logic [DATA_W-1:0] r_resp_data;

  logic w_cmd_fire;
  logic w_is_write;
  logic w_is_read;
  logic w_is_add;
  logic w_is_nop;
  logic w_unused_rs1_hi;

  assign w_cmd_fire      = cmd_valid && (r_state == S_IDLE);
  assign w_is_write      = (r_funct == c_FUNCT_WRITE);
  assign w_is_read       = (r_funct == c_FUNCT_READ);
  assign w_is_add        = (r_funct == c_FUNCT_ADD);
  assign w_is_nop        = !(w_is_write || w_is_read || w_is_add);
  assign w_unused_rs1_hi = ^cmd_rs1[DATA_W-1:ADDR_W];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and memory request decode; mem_* stay zero unless a request is driven.
  always_comb begin
    w_state_nxt = r_state;
    mem_rqvalid = 1'b0;
    mem_rqaddr  = '0;
    mem_wren    = 1'b0;
    mem_addr    = '0;
    mem_wrdata  = '0;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid) w_state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        if (w_is_nop) begin
          w_state_nxt = r_xd ? S_RESP : S_IDLE;
        end else begin
          mem_addr   = r_addr;
          mem_rqaddr = r_rd;
          if (w_is_write) begin
            mem_wren    = 1'b1;
            mem_wrdata  = r_rs2;
            mem_rqvalid = r_xd;
            w_state_nxt = r_xd ? S_WAIT : S_IDLE;
          end else begin
            mem_rqvalid = 1'b1;
            w_state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (mem_rdvalid) begin
          if (w_is_add)  w_state_nxt = S_WB;
          else           w_state_nxt = r_xd ? S_RESP : S_IDLE;
        end
      end
      S_WB: begin
        mem_wren    = 1'b1;
        mem_addr    = r_addr;
        mem_wrdata  = r_resp_data;
        w_state_nxt = r_xd ? S_RESP : S_IDLE;
      end
      S_RESP: begin
        if (resp_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_funct <= '0;
      r_addr  <= '0;
      r_rs2   <= '0;
      r_rd    <= '0;
      r_xd    <= 1'b0;
    end else if (w_cmd_fire) begin
      r_funct <= cmd_funct;
      r_addr  <= cmd_rs1[ADDR_W-1:0];
      r_rs2   <= cmd_rs2;
      r_rd    <= cmd_rd;
      r_xd    <= cmd_xd;
    end
  end

  // The ADD sum is parked in the response register so WB can write it back.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_resp_valid <= 1'b0;
      r_resp_rd    <= '0;
      r_resp_data  <= '0;
    end else begin
      r_resp_valid <= (w_state_nxt == S_RESP);
      if (r_state == S_ISSUE && w_is_nop && r_xd) begin
        r_resp_data <= '1;
        r_resp_rd   <= r_rd;
      end else if (r_state == S_WAIT && mem_rdvalid) begin
        if (w_is_add) begin
          r_resp_data <= mem_rddata + r_rs2;
          r_resp_rd   <= r_rd;
        end else begin
          r_resp_data <= mem_rddata;
          r_resp_rd   <= mem_rdaddr;
        end
      end
    end
  end

  assign cmd_ready  = (r_state == S_IDLE);
  assign busy       = (r_state != S_IDLE);
  assign resp_valid = r_resp_valid;
  assign resp_rd    = r_resp_rd;
  assign resp_data  = r_resp_data;

endmodule
`default_nettype wire

// File: tb/tb_mymem_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mymem_ctrl
// Description : Scoreboard bench for mymem_ctrl with a 1-cycle scratchpad model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mymem_ctrl;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 64;
  localparam int TAG_W  = 5;
  localparam logic [63:0] c_ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              cmd_valid = 1'b0;
  logic [6:0]        cmd_funct = '0;
  logic [DATA_W-1:0] cmd_rs1 = '0;
  logic [DATA_W-1:0] cmd_rs2 = '0;
  logic [TAG_W-1:0]  cmd_rd = '0;
  logic              cmd_xd = 1'b0;
  logic              resp_ready = 1'b1;
  logic              cmd_ready, resp_valid, mem_rqvalid, mem_wren, busy;
  logic [TAG_W-1:0]  resp_rd, mem_rqaddr, mem_rdaddr;
  logic [DATA_W-1:0] resp_data, mem_wrdata, mem_rddata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rdvalid;

  mymem_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
    .clock(clock), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_funct(cmd_funct),
    .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_rd(cmd_rd), .cmd_xd(cmd_xd),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rd(resp_rd), .resp_data(resp_data),
    .mem_rqvalid(mem_rqvalid), .mem_rqaddr(mem_rqaddr), .mem_wren(mem_wren),
    .mem_addr(mem_addr), .mem_wrdata(mem_wrdata),
    .mem_rdvalid(mem_rdvalid), .mem_rdaddr(mem_rdaddr), .mem_rddata(mem_rddata),
    .busy(busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Scratchpad model: read data is the pre-write value, returned one cycle later.
  logic [DATA_W-1:0] mem_arr [0:(1<<ADDR_W)-1];
  logic              m_rdvalid = 1'b0;
  logic [TAG_W-1:0]  m_rdaddr = '0;
  logic [DATA_W-1:0] m_rddata = '0;
  logic              stray = 1'b0;
  always @(posedge clock) begin
    m_rdvalid <= mem_rqvalid;
    if (mem_rqvalid) begin
      m_rdaddr <= mem_rqaddr;
      m_rddata <= mem_arr[mem_addr];
    end
    if (mem_wren) mem_arr[mem_addr] <= mem_wrdata;
  end
  assign mem_rdvalid = m_rdvalid | stray;
  assign mem_rdaddr  = m_rdaddr;
  assign mem_rddata  = m_rddata;

  int vectors = 0;
  int miscompares = 0;
  int fire_cyc = 0;
  int last_lat = -1;
  int wr_cnt = 0;
  int mem_act = 0;
  logic [ADDR_W-1:0] last_wr_addr = '0;
  logic [DATA_W-1:0] last_wr_data = '0;
  logic [TAG_W+DATA_W-1:0] exp_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic monitor();
    logic prev_v;
    logic [TAG_W+DATA_W-1:0] e;
    prev_v = 1'b0;
    forever begin
      @(negedge clock);
      if (mem_wren) begin
        wr_cnt++;
        last_wr_addr = mem_addr;
        last_wr_data = mem_wrdata;
      end
      if (mem_rqvalid || mem_wren || mem_addr != 0 || mem_wrdata != 0 || mem_rqaddr != 0) mem_act++;
      if (resp_valid && !prev_v) last_lat = cyc - fire_cyc;
      if (resp_valid && resp_ready) begin
        if (exp_q.size() == 0) begin
          check("resp_unexpected", {63'd0, resp_valid}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("resp_rd", {59'd0, resp_rd}, {59'd0, e[TAG_W+DATA_W-1:DATA_W]});
          check("resp_data", resp_data, e[DATA_W-1:0]);
        end
      end
      prev_v = resp_valid;
    end
  endtask

  task automatic issue(input logic [6:0] f, input logic [63:0] a, input logic [63:0] d,
                       input logic [TAG_W-1:0] rd, input logic xd);
    logic fired;
    fired = 1'b0;
    @(posedge clock); #1;
    cmd_valid = 1'b1; cmd_funct = f; cmd_rs1 = a; cmd_rs2 = d; cmd_rd = rd; cmd_xd = xd;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (cmd_ready) begin
        fire_cyc = cyc;
        fired = 1'b1;
        break;
      end
    end
    if (!fired) check("cmd_accept_timeout", {63'd0, cmd_ready}, 64'd1);
    @(posedge clock); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (!busy && !resp_valid) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) check("idle_timeout", {63'd0, busy}, 64'd0);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"}, {63'd0, busy}, 64'd0);
    check({tag, "_cmd_ready"}, {63'd0, cmd_ready}, 64'd1);
    check({tag, "_resp_valid"}, {63'd0, resp_valid}, 64'd0);
    check({tag, "_resp_rd"}, {59'd0, resp_rd}, 64'd0);
    check({tag, "_resp_data"}, resp_data, 64'd0);
    check({tag, "_mem_ctl"}, {58'd0, mem_rqvalid, mem_wren, 4'd0}, 64'd0);
    check({tag, "_mem_addr"}, {54'd0, mem_addr}, 64'd0);
    check({tag, "_mem_rqaddr"}, {59'd0, mem_rqaddr}, 64'd0);
    check({tag, "_mem_wrdata"}, mem_wrdata, 64'd0);
  endtask

  int w0, m0;

  initial begin
    fork
      monitor();
    join_none

    // Reset state
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_quiet("reset");
    @(posedge clock); #1;
    reset_n = 1'b1;

    // Preload: addr 7 = 1, addr 0 = all ones
    issue(7'd0, 64'd7, 64'd1, 5'd0, 1'b0);
    wait_idle();
    issue(7'd0, 64'd0, c_ONES, 5'd0, 1'b0);
    wait_idle();

    // WRITE addr 5 without response: single wren pulse, ready again in cycle 2
    w0 = wr_cnt;
    issue(7'd0, 64'd5, 64'hDEAD, 5'd1, 1'b0);
    @(negedge clock);
    check("wr_noxd_cmd_ready_c1", {63'd0, cmd_ready}, 64'd0);
    @(negedge clock);
    check("wr_noxd_cmd_ready_c2", {63'd0, cmd_ready}, 64'd1);
    check("wr_noxd_wren_pulses", wr_cnt - w0, 64'd1);
    check("wr_noxd_addr", {54'd0, last_wr_addr}, 64'd5);
    check("wr_noxd_data", last_wr_data, 64'hDEAD);

    // READ addr 5
    exp_q.push_back({5'd3, 64'hDEAD});
    issue(7'd1, 64'd5, 64'd0, 5'd3, 1'b1);
    wait_idle();
    check("read_latency", last_lat, 64'd3);

    // Swap over addr 7, then read back
    exp_q.push_back({5'd9, 64'h1});
    issue(7'd0, 64'd7, 64'h2, 5'd9, 1'b1);
    wait_idle();
    check("swap_latency", last_lat, 64'd3);
    exp_q.push_back({5'd10, 64'h2});
    issue(7'd1, 64'd7, 64'd0, 5'd10, 1'b1);
    wait_idle();

    // ADD wrap at addr 0 (upper rs1 bits ignored)
    w0 = wr_cnt;
    exp_q.push_back({5'd6, 64'h1});
    issue(7'd2, 64'hABC0_0000_0000_0000, 64'd2, 5'd6, 1'b1);
    wait_idle();
    check("add_latency", last_lat, 64'd4);
    check("add_wb_pulses", wr_cnt - w0, 64'd1);
    check("add_wb_addr", {54'd0, last_wr_addr}, 64'd0);
    check("add_wb_data", last_wr_data, 64'h1);
    exp_q.push_back({5'd12, 64'h1});
    issue(7'd1, 64'd0, 64'd0, 5'd12, 1'b1);
    wait_idle();

    // Backpressure in RESP
    resp_ready = 1'b0;
    exp_q.push_back({5'd11, 64'hDEAD});
    issue(7'd1, 64'd5, 64'd0, 5'd11, 1'b1);
    for (int i = 0; i < 20; i++) begin
      if (resp_valid) break;
      @(negedge clock);
    end
    for (int i = 0; i < 5; i++) begin
      check("bp_resp_valid", {63'd0, resp_valid}, 64'd1);
      check("bp_cmd_ready", {63'd0, cmd_ready}, 64'd0);
      check("bp_resp_rd", {59'd0, resp_rd}, 64'd11);
      check("bp_resp_data", resp_data, 64'hDEAD);
      @(negedge clock);
    end
    @(posedge clock); #1;
    resp_ready = 1'b1;
    @(negedge clock);
    @(negedge clock);
    check("bp_release_busy", {63'd0, busy}, 64'd0);
    check("bp_release_valid", {63'd0, resp_valid}, 64'd0);
    check("bp_release_ready", {63'd0, cmd_ready}, 64'd1);

    // NOP with and without response
    m0 = mem_act;
    exp_q.push_back({5'd4, c_ONES});
    issue(7'd5, 64'd9, 64'h1234, 5'd4, 1'b1);
    wait_idle();
    check("nop_latency", last_lat, 64'd2);
    check("nop_xd_mem_activity", mem_act - m0, 64'd0);
    issue(7'd5, 64'd9, 64'd0, 5'd4, 1'b0);
    @(negedge clock);
    check("nop_noxd_busy_c1", {63'd0, busy}, 64'd1);
    @(negedge clock);
    check("nop_noxd_busy_c2", {63'd0, busy}, 64'd0);
    check("nop_noxd_mem_activity", mem_act - m0, 64'd0);

    // Reset while an ADD is waiting on memory, then a stray read response
    issue(7'd2, 64'd0, 64'd5, 5'd7, 1'b1);
    @(posedge clock); #1;
    reset_n = 1'b0;
    #1;
    check_quiet("midreset");
    @(posedge clock); #1;
    reset_n = 1'b1;
    stray = 1'b1;
    @(posedge clock); #1;
    stray = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("post_stray_resp_valid", {63'd0, resp_valid}, 64'd0);
      check("post_stray_busy", {63'd0, busy}, 64'd0);
    end
    exp_q.push_back({5'd13, 64'h1});
    issue(7'd1, 64'd0, 64'd0, 5'd13, 1'b1);
    wait_idle();

    repeat (2) @(negedge clock);
    check("scoreboard_drained", exp_q.size(), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
